t06_luck_level_selector: RTL and testbench

Parametrised cyclic option selector for the team_06 game menu. It generalises the fixed three-level apple-luck picker to NUM_OPTS levels with up and down buttons, input synchronisation, edge detection and hold-to-repeat. The block sits between the raw pushbutton inputs and the game-logic consumers of the selected level, and accepts input only while the top-level FSM is in the selection state.

---
 rtl/t06_luck_level_selector.sv | 120 ++++++++++++
 tb/tb_t06_luck_level_selector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/t06_luck_level_selector.sv
`default_nettype none
// ============================================================================
// Module   : t06_luck_level_selector
// Brief    : Cyclic level selector driven by up/down buttons, with synchronisers,
//            edge detection and hold-to-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module t06_luck_level_selector #(
    parameter int                 NUM_OPTS     = 3,
    parameter int                 SEL_W        = 2,
    parameter int                 STATE_W      = 2,
    parameter logic [STATE_W-1:0] SEL_STATE    = 2'b01,
    parameter int                 RESET_SEL    = 0,
    parameter int                 REPEAT_DELAY = 16,
    parameter int                 REPEAT_RATE  = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               btn_up,
    input  logic               btn_dn,
    input  logic [STATE_W-1:0] state,
    output logic [SEL_W-1:0]   sel,
    output logic               changed,
    output logic               active
);

    localparam int               c_HMAX    = REPEAT_DELAY + REPEAT_RATE - 1;
    localparam int               c_HCNT_W  = (c_HMAX < 1) ? 1 : $clog2(c_HMAX + 1);
    localparam logic [c_HCNT_W-1:0] c_HMAX_V  = c_HCNT_W'(c_HMAX);
    localparam logic [c_HCNT_W-1:0] c_DELAY_V = c_HCNT_W'(REPEAT_DELAY);
    localparam logic [SEL_W-1:0]    c_LAST    = SEL_W'(NUM_OPTS - 1);
    localparam logic [SEL_W-1:0]    c_RESET_V = SEL_W'(RESET_SEL);

    logic r_s1_up, r_s2_up, r_prev_up;
    logic r_s1_dn, r_s2_dn, r_prev_dn;
    logic [c_HCNT_W-1:0] r_hcnt;
    logic [c_HCNT_W-1:0] w_hcnt_nxt;
    logic                r_armed;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic                r_changed;
    logic                r_active;

    logic w_in_sel, w_up, w_dn, w_pup, w_pdn;
    logic w_dir, w_pdir, w_same, w_press, w_repeat, w_step, w_armed_nxt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            {r_prev_up, r_s2_up, r_s1_up} <= 3'b000;
            {r_prev_dn, r_s2_dn, r_s1_dn} <= 3'b000;
        end else begin
            {r_prev_up, r_s2_up, r_s1_up} <= {r_s2_up, r_s1_up, btn_up};
            {r_prev_dn, r_s2_dn, r_s1_dn} <= {r_s2_dn, r_s1_dn, btn_dn};
        end
    end

    // Both buttons held counts as no direction, so releasing one of them
    // presents a fresh qualified edge for the other.
    assign w_in_sel = (state == SEL_STATE);
    assign w_up     = r_s2_up & ~r_s2_dn;
    assign w_dn     = r_s2_dn & ~r_s2_up;
    assign w_pup    = r_prev_up & ~r_prev_dn;
    assign w_pdn    = r_prev_dn & ~r_prev_up;
    assign w_dir    = w_up | w_dn;
    assign w_pdir   = w_pup | w_pdn;
    assign w_same   = (w_up & w_pup) | (w_dn & w_pdn);
    assign w_press  = (w_up & ~w_pup) | (w_dn & ~w_pdn);

    // A hold only repeats if it began with a press accepted in the selection
    // state; a button carried in from another state never auto-repeats.
    assign w_repeat    = (REPEAT_DELAY > 0) && r_armed && (r_hcnt == c_DELAY_V);
    assign w_step      = w_in_sel & w_dir & (w_press | w_repeat);
    assign w_armed_nxt = w_in_sel & w_dir & (w_press | (r_armed & w_same));

    always_comb begin
        w_hcnt_nxt = '0;
        if (w_in_sel && w_dir && !(w_pdir && !w_same)) begin
            if (r_hcnt == c_HMAX_V) begin
                w_hcnt_nxt = c_DELAY_V;
            end else begin
                w_hcnt_nxt = r_hcnt + c_HCNT_W'(1);
            end
        end
    end

    always_comb begin
        w_sel_nxt = r_sel;
        if (w_step) begin
            if (r_sel > c_LAST) begin
                w_sel_nxt = '0;
            end else if (w_up) begin
                w_sel_nxt = (r_sel == c_LAST) ? '0 : r_sel + SEL_W'(1);
            end else begin
                w_sel_nxt = (r_sel == '0) ? c_LAST : r_sel - SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_hcnt    <= '0;
            r_armed   <= 1'b0;
            r_sel     <= c_RESET_V;
            r_changed <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_hcnt    <= w_hcnt_nxt;
            r_armed   <= w_armed_nxt;
            r_sel     <= w_sel_nxt;
            r_changed <= w_step;
            r_active  <= w_in_sel;
        end
    end

    assign sel     = r_sel;
    assign changed = r_changed;
    assign active  = r_active;

endmodule
`default_nettype wire

// File: tb/tb_t06_luck_level_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_t06_luck_level_selector
// Brief    : Directed bench for three selector instances (3, 5 and 8 levels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_t06_luck_level_selector;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic [1:0] state = 2'b01;
    logic [1:0] sel3;
    logic [2:0] sel5, sel8;
    logic       chg3, chg5, chg8, act3, act5, act8;

    t06_luck_level_selector #(.NUM_OPTS(3), .SEL_W(2)) u3 (
        .clk(clk), .nrst(nrst), .btn_up(btn_up), .btn_dn(btn_dn), .state(state),
        .sel(sel3), .changed(chg3), .active(act3));
    t06_luck_level_selector #(.NUM_OPTS(5), .SEL_W(3)) u5 (
        .clk(clk), .nrst(nrst), .btn_up(btn_up), .btn_dn(btn_dn), .state(state),
        .sel(sel5), .changed(chg5), .active(act5));
    t06_luck_level_selector #(.NUM_OPTS(8), .SEL_W(3)) u8 (
        .clk(clk), .nrst(nrst), .btn_up(btn_up), .btn_dn(btn_dn), .state(state),
        .sel(sel8), .changed(chg8), .active(act8));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sel;
        int cyc;
    } exp_t;

    exp_t q[3][$];
    int   e[3];
    int   n_opts[3] = '{3, 5, 8};
    int   chg_cnt[3];
    int   checks = 0;
    int   errors = 0;
    logic signed [31:0] m_sel[3];
    logic               m_chg[3];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected level after one step, and the cycle whose changed pulse reports it.
    task automatic push_step(input bit up, input int when);
        for (int i = 0; i < 3; i++) begin
            if (up) e[i] = (e[i] == n_opts[i] - 1) ? 0 : e[i] + 1;
            else    e[i] = (e[i] == 0) ? n_opts[i] - 1 : e[i] - 1;
            q[i].push_back('{e[i], when});
        end
    endtask

    // Drive one button for 'hold' rising edges starting at the current negedge.
    task automatic hold_btn(input bit up, input int hold, input bit expect_steps);
        int n;
        n = cyc;
        if (expect_steps) begin
            push_step(up, n + 3);
            for (int off = 19; off <= hold + 1; off += 4) push_step(up, n + off);
        end
        if (up) btn_up = 1'b1; else btn_dn = 1'b1;
        repeat (hold) @(negedge clk);
        if (up) btn_up = 1'b0; else btn_dn = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #1;
        check("rst_sel3", sel3, 0);
        check("rst_sel5", sel5, 0);
        check("rst_sel8", sel8, 0);
        check("rst_chg3", chg3, 0);
        check("rst_chg8", chg8, 0);
        check("rst_act3", act3, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pending_u%0d", i), q[i].size(), 0);
            q[i].delete();
            e[i] = 0;
            chg_cnt[i] = 0;
        end
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    // Scoreboard: each changed pulse pops one expectation (value and cycle).
    always @(negedge clk) begin
        m_sel[0] = sel3; m_sel[1] = sel5; m_sel[2] = sel8;
        m_chg[0] = chg3; m_chg[1] = chg5; m_chg[2] = chg8;
        for (int i = 0; i < 3; i++) begin
            if (q[i].size() > 0 && q[i][0].cyc < cyc) begin
                check($sformatf("missed_step_u%0d", i), cyc, q[i][0].cyc);
                void'(q[i].pop_front());
            end
            if (m_chg[i] === 1'b1) begin
                exp_t x;
                chg_cnt[i]++;
                if (q[i].size() == 0) begin
                    check($sformatf("unexpected_step_u%0d", i), m_sel[i], -1);
                end else begin
                    x = q[i].pop_front();
                    check($sformatf("step_sel_u%0d", i), m_sel[i], x.sel);
                    check($sformatf("step_cycle_u%0d", i), cyc, x.cyc);
                end
            end
        end
    end

    initial begin
        int n, m, c_before;
        @(negedge clk);
        do_reset();
        @(negedge clk);
        check("active_after_reset", act3, 1);

        // Down from 0 wraps to the top level
        hold_btn(0, 3, 1);
        repeat (6) @(negedge clk);
        check("dn_wrap_sel5", sel5, 4);
        hold_btn(0, 3, 1);
        repeat (6) @(negedge clk);
        check("dn_second_sel5", sel5, 3);

        do_reset();
        for (int k = 0; k < 3; k++) begin
            hold_btn(1, 3, 1);
            repeat (6) @(negedge clk);
        end
        check("up3_wrap_sel3", sel3, 0);
        check("up3_changed_count", chg_cnt[0], 3);

        // Hold-to-repeat for 30 cycles
        do_reset();
        hold_btn(1, 30, 1);
        repeat (20) @(negedge clk);
        check("hold30_sel8", sel8, 5);

        // Presses outside the selection state are discarded
        state = 2'b10;
        repeat (2) @(negedge clk);
        check("inactive_act3", act3, 0);
        c_before = chg_cnt[2];
        hold_btn(1, 3, 0);
        repeat (4) @(negedge clk);
        hold_btn(0, 3, 0);
        repeat (4) @(negedge clk);
        hold_btn(1, 3, 0);
        repeat (4) @(negedge clk);
        check("inactive_sel8", sel8, 5);
        check("inactive_changed", chg_cnt[2], c_before);
        check("inactive_act8", act8, 0);

        // Re-entering with the button held must wait for a fresh press
        btn_up = 1'b1;
        repeat (5) @(negedge clk);
        state = 2'b01;
        repeat (25) @(negedge clk);
        check("reenter_held_sel8", sel8, 5);
        check("reenter_act5", act5, 1);
        btn_up = 1'b0;
        repeat (4) @(negedge clk);
        hold_btn(1, 3, 1);
        repeat (6) @(negedge clk);
        check("repress_sel8", sel8, 6);

        // Second button cancels; releasing the first gives one opposite step
        n = cyc;
        push_step(1, n + 3);
        btn_up = 1'b1;
        repeat (5) @(negedge clk);
        btn_dn = 1'b1;
        repeat (25) @(negedge clk);
        m = cyc;
        push_step(0, m + 3);
        btn_up = 1'b0;
        repeat (3) @(negedge clk);
        btn_dn = 1'b0;
        repeat (6) @(negedge clk);
        check("both_then_dn_sel8", sel8, 6);

        // Asynchronous reset in the middle of a hold
        do_reset();
        hold_btn(1, 3, 1);
        repeat (6) @(negedge clk);
        n = cyc;
        push_step(1, n + 3);
        btn_up = 1'b1;
        repeat (8) @(negedge clk);
        check("midhold_sel3", sel3, 2);
        do_reset();
        repeat (25) @(negedge clk);
        check("after_reset_idle_sel3", sel3, 0);
        hold_btn(1, 3, 1);
        repeat (6) @(negedge clk);
        check("after_reset_press_sel3", sel3, 1);

        for (int i = 0; i < 3; i++) check($sformatf("final_pending_u%0d", i), q[i].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
